lane_traffic_scheduler: RTL and testbench

//  Central scheduler for all vehicle lanes. Once per frame it decides which lanes advance, and in which direction.

---
 rtl/lane_traffic_scheduler.sv | 131 +++++++++++++
 tb/tb_lane_traffic_scheduler.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/lane_traffic_scheduler.sv
// Per-frame lane scheduler: decides which vehicle lanes advance each frame and
// owns the idle/run/pause/post-hit-freeze flow plus the level-based speed-up.
module lane_traffic_scheduler #(
  parameter int                         NUM_LANES    = 6,
  parameter logic [4*NUM_LANES-1:0]     PERIOD_TABLE = 24'h234_234,
  parameter logic [NUM_LANES-1:0]       LANE_DIR     = 6'b000111,
  parameter int                         MAX_LEVEL    = 7,
  parameter int                         HIT_FRAMES   = 60
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 frog_hit,
  input  logic                 level_up,
  output logic [NUM_LANES-1:0] lane_step,
  output logic [NUM_LANES-1:0] lane_dir,
  output logic [2:0]           level,
  output logic [1:0]           state,
  output logic                 freeze
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_PAUSE  = 2'd2;
  localparam logic [1:0] S_FREEZE = 2'd3;
  localparam int         HIT_W    = $clog2(HIT_FRAMES + 1);

  logic [1:0]       state_q, state_d;
  logic [2:0]       level_q, level_d;
  logic [HIT_W-1:0] hit_q, hit_d;
  logic             run_adv;     // RUN frame with no transition: lanes count
  logic             reload_all;  // restart every lane from its new period

  // Reload value: max(1, base - level) - 1, with a zero base behaving as 1.
  function automatic logic [3:0] eff_m1(input logic [3:0] base, input logic [2:0] lvl);
    logic [4:0] b;
    logic [4:0] d;
    b = (base == 4'd0) ? 5'd1 : {1'b0, base};
    d = (b > {2'b00, lvl}) ? (b - {2'b00, lvl}) : 5'd1;
    return 4'(d - 5'd1);
  endfunction

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    hit_d      = hit_q;
    run_adv    = 1'b0;
    reload_all = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (frog_hit) begin
          state_d = S_FREEZE;
          hit_d   = HIT_W'(HIT_FRAMES - 1);
        end else if (level_up) begin
          level_d    = (level_q < 3'(MAX_LEVEL)) ? level_q + 3'd1 : 3'(MAX_LEVEL);
          reload_all = 1'b1;
        end else if (pause) begin
          state_d = S_PAUSE;
        end else begin
          run_adv = 1'b1;
        end
      end
      S_PAUSE: begin
        if (!pause) state_d = S_RUN;
      end
      default: begin
        if (hit_q == '0) begin
          state_d    = S_RUN;
          reload_all = 1'b1;
        end else begin
          hit_d = hit_q - HIT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      level_q <= 3'd0;
      hit_q   <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      hit_q   <= hit_d;
    end
  end

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    localparam logic [3:0] BASE = PERIOD_TABLE[4*gi +: 4];
    logic [3:0] cnt_q, cnt_d;
    logic       step_q, step_d;

    always_comb begin
      cnt_d  = cnt_q;
      step_d = 1'b0;
      if (reload_all) begin
        cnt_d = eff_m1(BASE, level_d);
      end else if (run_adv) begin
        if (cnt_q == 4'd0) begin
          step_d = 1'b1;
          cnt_d  = eff_m1(BASE, level_q);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    end

    always_ff @(posedge frame_clk) begin
      if (Reset) begin
        cnt_q  <= eff_m1(BASE, 3'd0);
        step_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        step_q <= step_d;
      end
    end

    assign lane_step[gi] = step_q;
  end

  assign lane_dir = LANE_DIR;
  assign level    = level_q;
  assign state    = state_q;
  assign freeze   = (state_q == S_FREEZE);

endmodule

// File: tb/tb_lane_traffic_scheduler.sv
// Bench for lane_traffic_scheduler: directed phases plus a randomized phase,
// every frame checked against a frame-count reference model.
module tb_lane_traffic_scheduler;
  localparam int          NL  = 6;
  localparam logic [23:0] PT  = 24'h234_234;
  localparam logic [5:0]  DIR = 6'b000111;
  localparam int          MAXL = 7;
  localparam int          HITF = 60;

  logic          frame_clk, Reset, start, pause, frog_hit, level_up;
  logic [NL-1:0] lane_step, lane_dir;
  logic [2:0]    level;
  logic [1:0]    state;
  logic          freeze;

  int tests = 0;
  int fails = 0;

  // reference model: mode 0 idle, 1 run, 2 pause, 3 freeze
  int            m_state, m_level, m_frz;
  int            elapsed [NL];
  logic [NL-1:0] m_step;

  lane_traffic_scheduler #(
    .NUM_LANES(NL), .PERIOD_TABLE(PT), .LANE_DIR(DIR),
    .MAX_LEVEL(MAXL), .HIT_FRAMES(HITF)
  ) dut (
    .frame_clk(frame_clk), .Reset(Reset), .start(start), .pause(pause),
    .frog_hit(frog_hit), .level_up(level_up), .lane_step(lane_step),
    .lane_dir(lane_dir), .level(level), .state(state), .freeze(freeze)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  function automatic int eff(input int i, input int lvl);
    logic [23:0] pt;
    int b, d;
    pt = PT;
    b = int'(pt[4*i +: 4]);
    if (b == 0) b = 1;
    d = b - lvl;
    return (d < 1) ? 1 : d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic r, input logic s, input logic p, input logic h, input logic l);
    m_step = '0;
    if (r) begin
      m_state = 0; m_level = 0; m_frz = 0;
      for (int i = 0; i < NL; i++) elapsed[i] = 0;
      return;
    end
    case (m_state)
      0: if (s) m_state = 1;
      1: begin
        if (h) begin
          m_state = 3; m_frz = 1;
        end else if (l) begin
          if (m_level < MAXL) m_level++;
          for (int i = 0; i < NL; i++) elapsed[i] = 0;
        end else if (p) begin
          m_state = 2;
        end else begin
          for (int i = 0; i < NL; i++) begin
            elapsed[i]++;
            m_step[i] = (elapsed[i] % eff(i, m_level) == 0);
          end
        end
      end
      2: if (!p) m_state = 1;
      default: begin
        if (m_frz == HITF) begin
          m_state = 1;
          for (int i = 0; i < NL; i++) elapsed[i] = 0;
        end else m_frz++;
      end
    endcase
  endtask

  task automatic cyc(input logic r, input logic s, input logic p, input logic h, input logic l);
    Reset = r; start = s; pause = p; frog_hit = h; level_up = l;
    @(posedge frame_clk);
    model(r, s, p, h, l);
    #1;
    $display("[TB] t=%0t rst=%b st=%b pa=%b hit=%b lu=%b -> state=%0d level=%0d frz=%b step=%b",
             $time, r, s, p, h, l, state, level, freeze, lane_step);
    chk("state", 32'(state), 32'(m_state));
    chk("level", 32'(level), 32'(m_level));
    chk("freeze", 32'(freeze), 32'(m_state == 3));
    chk("lane_step", 32'(lane_step), 32'(m_step));
    chk("lane_dir", 32'(lane_dir), 32'(DIR));
  endtask

  initial begin
    int c0, c1, c2, nfrz, guard;
    Reset = 1'b1; start = 1'b0; pause = 1'b0; frog_hit = 1'b0; level_up = 1'b0;
    m_state = 0; m_level = 0; m_frz = 0; m_step = '0;
    for (int i = 0; i < NL; i++) elapsed[i] = 0;

    // reset, start, base cadence over 12 frames
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    c0 = 0; c1 = 0; c2 = 0;
    for (int k = 0; k < 12; k++) begin
      cyc(0, 0, 0, 0, 0);
      c0 += int'(lane_step[0]); c1 += int'(lane_step[1]); c2 += int'(lane_step[2]);
    end
    chk("lane0_steps_l0", 32'(c0), 32'd3);
    chk("lane1_steps_l0", 32'(c1), 32'd4);
    chk("lane2_steps_l0", 32'(c2), 32'd6);

    // three level-ups: lanes 0 and 2 collapse to every frame
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 1);
    chk("level_after_3", 32'(level), 32'd3);
    c0 = 0; c2 = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(0, 0, 0, 0, 0);
      c0 += int'(lane_step[0]); c2 += int'(lane_step[2]);
    end
    chk("lane0_steps_l3", 32'(c0), 32'd6);
    chk("lane2_steps_l3", 32'(c2), 32'd6);
    for (int k = 0; k < 10; k++) cyc(0, 0, 0, 0, 1);
    chk("level_saturated", 32'(level), 32'd7);

    // back to level 0 and pause mid-run for 20 frames
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) cyc(0, 0, 1, 0, 0);
    for (int k = 0; k < 12; k++) cyc(0, 0, 0, 0, 0);

    // hit with simultaneous level_up, second hit mid-freeze
    cyc(0, 0, 0, 1, 1);
    chk("level_held_on_hit", 32'(level), 32'd0);
    nfrz = 1;
    guard = 0;
    while (freeze && guard < 100) begin
      cyc(0, 0, 0, (nfrz == 30), (nfrz == 31));
      if (freeze) nfrz++;
      guard++;
    end
    chk("freeze_frames", 32'(nfrz), 32'(HITF));
    chk("state_after_freeze", 32'(state), 32'd1);
    for (int k = 0; k < 8; k++) cyc(0, 0, 0, 0, 0);

    // randomized play
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(99) < 1), ($urandom_range(99) < 30), ($urandom_range(99) < 15),
          ($urandom_range(99) < 2), ($urandom_range(99) < 6));
    end

    // reset in the middle of a freeze at level 5
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 0);
    chk("level_in_freeze", 32'(level), 32'd5);
    cyc(1, 0, 0, 0, 0);
    chk("rst_frz_state", 32'(state), 32'd0);
    chk("rst_frz_level", 32'(level), 32'd0);
    chk("rst_frz_freeze", 32'(freeze), 32'd0);
    chk("rst_frz_step", 32'(lane_step), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
